blink_monitor: RTL and testbench
================================

BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of the observed LED bus.
REQ-002 SHALL have parameter CNT_W, default 16, width of the interval counter and of the period output.
REQ-003 SHALL have parameter LOCK_CNT, default 4, number of consecutive matching intervals required to reach lock.
REQ-004 SHALL have port clk  input  1  clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port din  input  WIDTH  observed blink bus, synchronous to clk.
REQ-007 SHALL have port clr_err  input  1  single-cycle request to clear the sticky error and restart acquisition.
REQ-008 SHALL have port locked  output  1  high while in state LOCK.
REQ-009 SHALL have port period  output  CNT_W  last accepted toggle interval, in clk cycles.
REQ-010 SHALL have port period_vld  output  1  one-cycle pulse when period updates in LOCK.
REQ-011 SHALL have port err  output  1  sticky error flag, high while in state ERR.
REQ-012 SHALL have port err_code  output  2  00 none, 01 period mismatch, 10 partial toggle, 11 stall timeout.

Function
REQ-013 SHALL register din into din_q every cycle; the reference for comparison is din_q.
REQ-014 SHALL detect a valid toggle when din == ~din_q (every bit flips), and a partial toggle when din != din_q and din != ~din_q.
REQ-015 SHALL keep an interval counter that loads 1 on a valid toggle, increments by 1 on every other cycle, and saturates at all-ones.
REQ-016 SHALL take the interval of a toggle as the counter value on that cycle, so a bus flipping every cycle has interval 1; a saturated interval never matches.
REQ-017 SHALL implement states IDLE, ACQ, LOCK and ERR.
REQ-018 IDLE: on a valid toggle, go to ACQ with no reference period and match count 0; partial toggles SHALL be ignored.
REQ-019 ACQ: on the first valid toggle, store the interval as the reference. On later toggles, an equal interval increments the match count; an unequal interval replaces the reference and clears the count. Reaching LOCK_CNT moves to LOCK.
REQ-020 LOCK: a valid toggle with interval equal to the reference SHALL set period = interval and pulse period_vld; an unequal interval SHALL go to ERR with code 01.
REQ-021 A partial toggle in ACQ or LOCK SHALL go to ERR with code 10.
REQ-022 ERR: err = 1 and locked = 0; err_code holds until clr_err, which moves to IDLE and clears err and err_code.
REQ-023 If clr_err coincides with a new error condition, the clear SHALL win and the next state is IDLE.
REQ-024 Every output SHALL be registered and update on the clock edge at which the triggering din value is first sampled; there is no further latency.

Reset
REQ-025 When reset is asserted, the block SHALL enter IDLE with din_q = 0, counter = 0, locked = 0, period = 0, period_vld = 0, err = 0 and err_code = 00; this applies in any state, including mid-LOCK.

Configuration
REQ-026 With macro BLINK_MON_TIMEOUT_EN defined, LOCK SHALL go to ERR with code 11 when the counter exceeds 2 × reference without a toggle.
REQ-027 Without BLINK_MON_TIMEOUT_EN, no timeout logic SHALL exist, code 11 SHALL never be produced, and LOCK SHALL persist through arbitrarily long stalls.

Verification
REQ-028 din alternates 00/FF every cycle after reset -> locked rises on the 6th toggle; period = 1 with period_vld on each later toggle.
REQ-029 din toggles every 5 cycles until locked, then one interval is 6 -> err = 1, err_code = 01, locked = 0 on that edge.
REQ-030 While locked with din = FF, din changes to 0F -> err = 1, err_code = 10.
REQ-031 In ERR, pulse clr_err, including on the same cycle as a partial toggle -> next state IDLE, err = 0, err_code = 00; re-acquisition succeeds.
REQ-032 Reset asserted while locked with period = 5 -> all outputs 0 on the next edge, and the state is IDLE.
REQ-033 Locked with reference 3, then din is held static -> with BLINK_MON_TIMEOUT_EN, err_code = 11 when the counter reaches 7; without it, locked stays 1.

Source files
------------

// File: rtl/blink_monitor_if.sv
// Handshake bundle between an observer and blink_monitor.
// Ports: din/clr_err flow master->slave; locked, period, period_vld, err and
// err_code flow slave->master. WIDTH and CNT_W must match the monitor's.
interface blink_monitor_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output din, clr_err,
        input  locked, period, period_vld, err, err_code
    );

    modport slave (
        input  din, clr_err,
        output locked, period, period_vld, err, err_code
    );
endinterface

// File: rtl/blink_monitor.sv
// Watches a blink bus, locks onto a steady full-bus toggle period and flags errors.
// Ports: clk, reset (sync, active-high), bus (slave modport: din, clr_err in;
// locked, period, period_vld, err, err_code out). All outputs registered, no extra latency.
// Optional: define BLINK_MON_TIMEOUT_EN to flag a stall (code 11) while locked.
module blink_monitor #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic            clk,
    input  logic            reset,
    blink_monitor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCK, ERR} state_t;

    localparam int               MW      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] din_q;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] ref_q, ref_nxt;
    logic [CNT_W-1:0] period_q, period_nxt;
    logic [MW-1:0]    mcnt_q, mcnt_nxt;
    logic             have_ref_q, have_ref_nxt;
    logic [1:0]       code_q, code_nxt;
    logic             pv_q, pv_nxt;
    logic             locked_q, err_q;
    logic             tog, part, match;

    // Full inversion is a valid toggle; any other change is a partial toggle.
    assign tog   = (bus.din == ~din_q);
    assign part  = (bus.din != din_q) && !tog;
    // cnt already holds the interval of a toggle seen this cycle.
    assign match = (cnt == ref_q) && (cnt != CNT_MAX);

    always_comb begin
        cnt_nxt = cnt;
        if (tog)
            cnt_nxt = CNT_W'(1);
        else if (cnt != CNT_MAX)
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_comb begin
        state_nxt    = state;
        ref_nxt      = ref_q;
        mcnt_nxt     = mcnt_q;
        have_ref_nxt = have_ref_q;
        period_nxt   = period_q;
        code_nxt     = code_q;
        pv_nxt       = 1'b0;

        // A clear beats any error detected on the same cycle.
        if (bus.clr_err) begin
            state_nxt = IDLE;
            code_nxt  = 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (tog) begin
                        state_nxt    = ACQ;
                        have_ref_nxt = 1'b0;
                        mcnt_nxt     = '0;
                    end
                end
                ACQ: begin
                    if (part) begin
                        state_nxt = ERR;
                        code_nxt  = 2'b10;
                    end else if (tog) begin
                        if (!have_ref_q) begin
                            ref_nxt      = cnt;
                            have_ref_nxt = 1'b1;
                            mcnt_nxt     = '0;
                        end else if (match) begin
                            mcnt_nxt = mcnt_q + MW'(1);
                            if (mcnt_q + MW'(1) == MW'(LOCK_CNT))
                                state_nxt = LOCK;
                        end else begin
                            ref_nxt  = cnt;
                            mcnt_nxt = '0;
                        end
                    end
                end
                LOCK: begin
                    if (part) begin
                        state_nxt = ERR;
                        code_nxt  = 2'b10;
                    end else if (tog) begin
                        if (match) begin
                            period_nxt = cnt;
                            pv_nxt     = 1'b1;
                        end else begin
                            state_nxt = ERR;
                            code_nxt  = 2'b01;
                        end
                    end
`ifdef BLINK_MON_TIMEOUT_EN
                    // Stall: the counter about to be loaded exceeds twice the reference.
                    else if ({1'b0, cnt_nxt} > {ref_q, 1'b0}) begin
                        state_nxt = ERR;
                        code_nxt  = 2'b11;
                    end
`endif
                end
                ERR: begin
                    state_nxt = ERR;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            din_q      <= '0;
            cnt        <= '0;
            ref_q      <= '0;
            mcnt_q     <= '0;
            have_ref_q <= 1'b0;
            period_q   <= '0;
            code_q     <= 2'b00;
            pv_q       <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            din_q      <= bus.din;
            cnt        <= cnt_nxt;
            ref_q      <= ref_nxt;
            mcnt_q     <= mcnt_nxt;
            have_ref_q <= have_ref_nxt;
            period_q   <= period_nxt;
            code_q     <= code_nxt;
            pv_q       <= pv_nxt;
            locked_q   <= (state_nxt == LOCK);
            err_q      <= (state_nxt == ERR);
        end
    end

    assign bus.locked     = locked_q;
    assign bus.period     = period_q;
    assign bus.period_vld = pv_q;
    assign bus.err        = err_q;
    assign bus.err_code   = code_q;
endmodule

// File: tb/tb_blink_monitor.sv
// Self-checking bench for blink_monitor: directed scenarios plus randomized
// traffic, all compared against a cycle-count based reference model.
module tb_blink_monitor;
    localparam int LOCK_CNT = 4;
    localparam int CMAX     = 65535;
    localparam int S_IDLE = 0, S_ACQ = 1, S_LOCK = 2, S_ERR = 3;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    blink_monitor_if #(.WIDTH(8), .CNT_W(16)) bif ();

    blink_monitor #(.WIDTH(8), .CNT_W(16), .LOCK_CNT(LOCK_CNT)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: intervals are edge-count differences since the last toggle.
    int         m_st, m_edge, m_last, m_ref, m_m, m_period, m_code;
    bit         m_have, m_pv;
    logic [7:0] m_dq;
    logic [7:0] cur;

    function automatic bit m_locked(); return m_st == S_LOCK; endfunction
    function automatic bit m_err();    return m_st == S_ERR;  endfunction

    task automatic model_step(input logic [7:0] d, input logic c, input logic r);
        int iv;
        bit tg, pt;
`ifdef BLINK_MON_TIMEOUT_EN
        int nx;
`endif
        m_edge++;
        m_pv = 0;
        if (r) begin
            m_st = S_IDLE; m_dq = 8'h00; m_last = m_edge + 1;
            m_period = 0; m_code = 0; m_ref = 0; m_have = 0; m_m = 0;
        end else begin
            tg = (d == ~m_dq);
            pt = (d != m_dq) && !tg;
            iv = m_edge - m_last;
            if (iv > CMAX) iv = CMAX;
`ifdef BLINK_MON_TIMEOUT_EN
            nx = tg ? 1 : ((iv + 1 > CMAX) ? CMAX : iv + 1);
`endif
            if (tg) m_last = m_edge;
            if (c) begin
                m_st = S_IDLE; m_code = 0;
            end else begin
                case (m_st)
                    S_IDLE: if (tg) begin m_st = S_ACQ; m_have = 0; m_m = 0; end
                    S_ACQ: begin
                        if (pt) begin m_st = S_ERR; m_code = 2; end
                        else if (tg) begin
                            if (!m_have) begin m_ref = iv; m_have = 1; m_m = 0; end
                            else if (iv == m_ref && iv != CMAX) begin
                                m_m++;
                                if (m_m == LOCK_CNT) m_st = S_LOCK;
                            end else begin m_ref = iv; m_m = 0; end
                        end
                    end
                    S_LOCK: begin
                        if (pt) begin m_st = S_ERR; m_code = 2; end
                        else if (tg) begin
                            if (iv == m_ref && iv != CMAX) begin m_period = iv; m_pv = 1; end
                            else begin m_st = S_ERR; m_code = 1; end
                        end
`ifdef BLINK_MON_TIMEOUT_EN
                        else if (nx > 2 * m_ref) begin m_st = S_ERR; m_code = 3; end
`endif
                    end
                    default: ;
                endcase
            end
            m_dq = d;
        end
    endtask

    // Drive one cycle, step the model on the edge, sample 1 time unit later.
    task automatic cycle(input logic [7:0] d, input logic c, input logic r);
        bif.din = d; bif.clr_err = c; rst = r;
        @(posedge clk);
        model_step(d, c, r);
        #1;
    endtask

    task automatic do_reset();
        cur = 8'h00;
        cycle(cur, 1'b0, 1'b1);
    endtask

    // Hold n-1 cycles, flip the whole bus on the n-th.
    task automatic run_interval(input int n);
        for (int i = 0; i < n - 1; i++) cycle(cur, 1'b0, 1'b0);
        cur = ~cur;
        cycle(cur, 1'b0, 1'b0);
    endtask

    task automatic lock_at(input int n);
        for (int i = 0; i < 12 && !m_locked(); i++) run_interval(n);
    endtask

    task automatic test_reset();
        cur = 8'h00;
        cycle(cur, 1'b0, 1'b1);
        cycle(cur, 1'b0, 1'b1);
        total++; if (bif.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", bif.locked); end
        total++; if (bif.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bif.err); end
        total++; if (bif.err_code !== 2'b00) begin bad++; $display("FAIL reset_code got=%b want=00", bif.err_code); end
        total++; if (bif.period !== 16'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", bif.period); end
        total++; if (bif.period_vld !== 1'b0) begin bad++; $display("FAIL reset_pvld got=%b want=0", bif.period_vld); end
    endtask

    task automatic test_fast_lock();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cur = ~cur;
            cycle(cur, 1'b0, 1'b0);
            total++; if (bif.locked !== (k >= 6)) begin bad++; $display("FAIL fast_locked toggle=%0d got=%b want=%b", k, bif.locked, k >= 6); end
            total++; if (bif.period_vld !== (k >= 7)) begin bad++; $display("FAIL fast_pvld toggle=%0d got=%b want=%b", k, bif.period_vld, k >= 7); end
            if (k >= 7) begin
                total++; if (bif.period !== 16'd1) begin bad++; $display("FAIL fast_period toggle=%0d got=%0d want=1", k, bif.period); end
            end
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        for (int i = 0; i < 12 && !m_locked(); i++) begin
            run_interval(5);
            total++; if (bif.locked !== m_locked()) begin bad++; $display("FAIL mis_acq_locked got=%b want=%b", bif.locked, m_locked()); end
        end
        total++; if (bif.locked !== 1'b1) begin bad++; $display("FAIL mis_reach_lock got=%b want=1", bif.locked); end
        run_interval(6);
        total++; if (bif.err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b want=1", bif.err); end
        total++; if (bif.err_code !== 2'b01) begin bad++; $display("FAIL mis_code got=%b want=01", bif.err_code); end
        total++; if (bif.locked !== 1'b0) begin bad++; $display("FAIL mis_locked got=%b want=0", bif.locked); end
    endtask

    task automatic test_partial_clr();
        do_reset();
        lock_at(2);
        if (cur != 8'hFF) run_interval(2);
        total++; if (bif.locked !== 1'b1) begin bad++; $display("FAIL part_pre_locked got=%b want=1", bif.locked); end
        cycle(8'h0F, 1'b0, 1'b0);
        total++; if (bif.err !== 1'b1) begin bad++; $display("FAIL part_err got=%b want=1", bif.err); end
        total++; if (bif.err_code !== 2'b10) begin bad++; $display("FAIL part_code got=%b want=10", bif.err_code); end
        // Clear on the same cycle as another partial toggle.
        cur = 8'h3C;
        cycle(cur, 1'b1, 1'b0);
        total++; if (bif.err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", bif.err); end
        total++; if (bif.err_code !== 2'b00) begin bad++; $display("FAIL clr_code got=%b want=00", bif.err_code); end
        total++; if (bif.locked !== 1'b0) begin bad++; $display("FAIL clr_locked got=%b want=0", bif.locked); end
        lock_at(3);
        total++; if (bif.locked !== 1'b1) begin bad++; $display("FAIL reacq_locked got=%b want=1", bif.locked); end
        total++; if (bif.err !== 1'b0) begin bad++; $display("FAIL reacq_err got=%b want=0", bif.err); end
    endtask

    task automatic test_reset_lock();
        do_reset();
        lock_at(5);
        run_interval(5);
        total++; if (bif.period !== 16'd5) begin bad++; $display("FAIL rl_period got=%0d want=5", bif.period); end
        total++; if (bif.period_vld !== 1'b1) begin bad++; $display("FAIL rl_pvld got=%b want=1", bif.period_vld); end
        cycle(cur, 1'b0, 1'b1);
        cur = 8'h00;
        total++; if ({bif.locked, bif.err, bif.err_code, bif.period_vld, bif.period} !== 21'd0) begin
            bad++; $display("FAIL rl_outputs got=%b/%b/%b/%b/%0d want=all zero", bif.locked, bif.err, bif.err_code, bif.period_vld, bif.period);
        end
        // IDLE ignores partial toggles.
        cycle(8'h55, 1'b0, 1'b0);
        total++; if (bif.err !== 1'b0 || bif.locked !== 1'b0) begin bad++; $display("FAIL rl_idle err=%b locked=%b want=0/0", bif.err, bif.locked); end
        cur = 8'h55;
    endtask

    task automatic test_stall();
        do_reset();
        lock_at(3);
        total++; if (bif.locked !== 1'b1) begin bad++; $display("FAIL stall_pre_locked got=%b want=1", bif.locked); end
        for (int i = 1; i <= 12; i++) begin
            cycle(cur, 1'b0, 1'b0);
`ifdef BLINK_MON_TIMEOUT_EN
            // Counter holds i+1 after the i-th idle edge; 7 first exceeds 2*3.
            total++; if (bif.err !== (i >= 6)) begin bad++; $display("FAIL stall_err hold=%0d got=%b want=%b", i, bif.err, i >= 6); end
            if (i >= 6) begin
                total++; if (bif.err_code !== 2'b11) begin bad++; $display("FAIL stall_code hold=%0d got=%b want=11", i, bif.err_code); end
            end
`else
            total++; if (bif.locked !== 1'b1) begin bad++; $display("FAIL stall_locked hold=%0d got=%b want=1", i, bif.locked); end
`endif
            total++; if (bif.err_code !== 2'(m_code)) begin bad++; $display("FAIL stall_model_code hold=%0d got=%b want=%0d", i, bif.err_code, m_code); end
        end
    endtask

    task automatic test_random();
        int         p, h;
        logic [7:0] d;
        logic       c, r;
        logic [20:0] exp_v, got_v;
        do_reset();
        p = 2; h = 0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom % 250) == 0;
            if (($urandom % 40) == 0) p = $urandom_range(1, 4);
            if (h + 1 >= p) begin d = ~cur; h = 0; end
            else begin d = cur; h++; end
            if (($urandom % 60) == 0) d = cur ^ (8'h01 << ($urandom % 8));
            c = (m_st == S_ERR) && (($urandom % 6) == 0);
            cur = r ? 8'h00 : d;
            cycle(d, c, r);
            if (r) cur = 8'h00;
            exp_v = {m_locked(), m_err(), 2'(m_code), m_pv, 16'(m_period)};
            got_v = {bif.locked, bif.err, bif.err_code, bif.period_vld, bif.period};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL rand cyc=%0d got lk/er/cd/pv/per=%b/%b/%b/%b/%0d want=%b/%b/%b/%b/%0d",
                         i, got_v[20], got_v[19], got_v[18:17], got_v[16], got_v[15:0],
                         exp_v[20], exp_v[19], exp_v[18:17], exp_v[16], exp_v[15:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; bif.din = 8'h00; bif.clr_err = 1'b0;
        m_edge = 0; m_last = 1; m_st = S_IDLE; m_dq = 8'h00;
        m_ref = 0; m_m = 0; m_period = 0; m_code = 0; m_have = 0; m_pv = 0;
        cur = 8'h00;
        test_reset();
        test_fast_lock();
        test_mismatch();
        test_partial_clr();
        test_reset_lock();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
